// File: rtl/rvfi_retire_serializer.sv
// RVFI retirement serializer: queues up to NRET retirements per cycle, replays one per cycle.
// Optional order checking is enabled by defining RVFI_SERIAL_ORDERCHK_EN.
module rvfi_retire_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NRET-1:0]           in_valid,
    input  logic [NRET*64-1:0]        in_order,
    input  logic [NRET*32-1:0]        in_insn,
    input  logic [NRET-1:0]           in_trap,
    input  logic [NRET*XLEN-1:0]      in_pc_rdata,
    input  logic [NRET*XLEN-1:0]      in_pc_wdata,
    input  logic [NRET*5-1:0]         in_rd_addr,
    input  logic [NRET*XLEN-1:0]      in_rd_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_order,
    output logic [31:0]               out_insn,
    output logic                      out_trap,
    output logic [XLEN-1:0]           out_pc_rdata,
    output logic [XLEN-1:0]           out_pc_wdata,
    output logic [4:0]                out_rd_addr,
    output logic [XLEN-1:0]           out_rd_wdata,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      order_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } ent_t;

    ent_t          mem_q [DEPTH];
    ent_t          in_ent [NRET];
    ent_t          head;
    logic [PW-1:0] rd_q, wr_q;
    logic [PW-1:0] slot [NRET];
    logic [LW-1:0] level_q, level_d;
    logic [LW:0]   n, cnt, free;
    logic          ovf_q;
    logic          pop, accept, drop;

    // Unpack the flat per-channel buses and compute compacted write slots.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NRET; i++) begin
            in_ent[i].order    = in_order[64*i +: 64];
            in_ent[i].insn     = in_insn[32*i +: 32];
            in_ent[i].trap     = in_trap[i];
            in_ent[i].pc_rdata = in_pc_rdata[XLEN*i +: XLEN];
            in_ent[i].pc_wdata = in_pc_wdata[XLEN*i +: XLEN];
            in_ent[i].rd_addr  = in_rd_addr[5*i +: 5];
            in_ent[i].rd_wdata = in_rd_wdata[XLEN*i +: XLEN];
            slot[i]            = PW'(cnt);
            cnt                = cnt + (LW+1)'(in_valid[i]);
        end
        n = cnt;
    end

    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    // A slot freed by this cycle's pop is reusable by this cycle's push.
    assign free      = (LW+1)'(DEPTH) - {1'b0, level_q} + (LW+1)'(pop);
    assign accept    = (n != '0) && (n <= free);
    assign drop      = (n > free);
    assign level_d   = LW'({1'b0, level_q} + (accept ? n : '0) - (LW+1)'(pop));

    // Queue storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
        end else begin
            if (pop) rd_q <= rd_q + PW'(1);
            if (accept) begin
                for (int i = 0; i < NRET; i++) begin
                    if (in_valid[i]) mem_q[wr_q + slot[i]] <= in_ent[i];
                end
                wr_q <= wr_q + PW'(n);
            end
            if (drop) ovf_q <= 1'b1;
            level_q <= level_d;
        end
    end

    assign head         = mem_q[rd_q];
    assign out_order    = head.order;
    assign out_insn     = head.insn;
    assign out_trap     = head.trap;
    assign out_pc_rdata = head.pc_rdata;
    assign out_pc_wdata = head.pc_wdata;
    assign out_rd_addr  = head.rd_addr;
    assign out_rd_wdata = head.rd_wdata;
    assign level        = level_q;
    assign overflow     = ovf_q;

`ifdef RVFI_SERIAL_ORDERCHK_EN
    logic        base_q, err_q;
    logic [63:0] last_q;
    logic        grp_bad, grp_have;
    logic [63:0] grp_prev;

    // Orders accepted together must be consecutive in channel order.
    always_comb begin
        grp_bad  = 1'b0;
        grp_have = 1'b0;
        grp_prev = '0;
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                if (grp_have && in_ent[i].order != grp_prev + 64'd1) grp_bad = 1'b1;
                grp_prev = in_ent[i].order;
                grp_have = 1'b1;
            end
        end
    end

    // First pop sets the baseline; each later pop must follow the last by one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            base_q <= 1'b0;
            last_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (pop) begin
                base_q <= 1'b1;
                last_q <= out_order;
                if (base_q && out_order != last_q + 64'd1) err_q <= 1'b1;
            end
            if (accept && grp_bad) err_q <= 1'b1;
        end
    end

    assign order_err = err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Scoreboard bench for rvfi_retire_serializer (NRET=2, XLEN=32, DEPTH=8).
// Honours RVFI_SERIAL_ORDERCHK_EN for the order_err expectation.
module tb_rvfi_retire_serializer;

    localparam int NRET  = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } ent_t;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic [NRET-1:0]      in_valid = '0;
    logic [NRET*64-1:0]   in_order = '0;
    logic [NRET*32-1:0]   in_insn = '0;
    logic [NRET-1:0]      in_trap = '0;
    logic [NRET*XLEN-1:0] in_pc_rdata = '0;
    logic [NRET*XLEN-1:0] in_pc_wdata = '0;
    logic [NRET*5-1:0]    in_rd_addr = '0;
    logic [NRET*XLEN-1:0] in_rd_wdata = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [63:0]          out_order;
    logic [31:0]          out_insn;
    logic                 out_trap;
    logic [XLEN-1:0]      out_pc_rdata;
    logic [XLEN-1:0]      out_pc_wdata;
    logic [4:0]           out_rd_addr;
    logic [XLEN-1:0]      out_rd_wdata;
    logic [3:0]           level;
    logic                 overflow;
    logic                 order_err;

    always #5 clock = ~clock;

    rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
        .in_trap(in_trap), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
        .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_order(out_order), .out_insn(out_insn), .out_trap(out_trap),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .level(level), .overflow(overflow), .order_err(order_err)
    );

    int          n_run = 0;
    int          n_fail = 0;
    ent_t        sb[$];
    logic        ovf_m = 1'b0;
    logic        err_m = 1'b0;
    logic        base_m = 1'b0;
    logic [63:0] last_m = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] o);
        ent_t e;
        e.order    = o;
        e.insn     = $urandom;
        e.trap     = 1'($urandom_range(0, 1));
        e.pc_rdata = $urandom;
        e.pc_wdata = $urandom;
        e.rd_addr  = 5'($urandom_range(0, 31));
        e.rd_wdata = $urandom;
        return e;
    endfunction

    function automatic logic err_exp();
`ifdef RVFI_SERIAL_ORDERCHK_EN
        return err_m;
`else
        return 1'b0;
`endif
    endfunction

    // One clock of stimulus; checks state at negedge, then updates the model.
    task automatic cyc(input logic [1:0] v, input logic [63:0] o0,
                       input logic [63:0] o1, input logic rdy);
        ent_t e0, e1, h;
        int   n, fr;
        e0 = mk(o0);
        e1 = mk(o1);
        in_valid    = v;
        in_order    = {e1.order, e0.order};
        in_insn     = {e1.insn, e0.insn};
        in_trap     = {e1.trap, e0.trap};
        in_pc_rdata = {e1.pc_rdata, e0.pc_rdata};
        in_pc_wdata = {e1.pc_wdata, e0.pc_wdata};
        in_rd_addr  = {e1.rd_addr, e0.rd_addr};
        in_rd_wdata = {e1.rd_wdata, e0.rd_wdata};
        out_ready   = rdy;
        @(negedge clock);
        chk("out_valid", 256'(out_valid), 256'(sb.size() != 0));
        chk("level", 256'(level), 256'(sb.size()));
        chk("overflow", 256'(overflow), 256'(ovf_m));
        chk("order_err", 256'(order_err), 256'(err_exp()));
        if (rdy && sb.size() != 0) begin
            h = sb.pop_front();
            chk("head", 256'({out_order, out_insn, out_trap, out_pc_rdata,
                              out_pc_wdata, out_rd_addr, out_rd_wdata}), 256'(h));
            if (base_m && h.order != last_m + 64'd1) err_m = 1'b1;
            last_m = h.order;
            base_m = 1'b1;
        end
        n  = int'(v[0]) + int'(v[1]);
        fr = DEPTH - sb.size();
        if (n > 0) begin
            if (n <= fr) begin
                if (v[0]) sb.push_back(e0);
                if (v[1]) sb.push_back(e1);
                if (v == 2'b11 && o1 != o0 + 64'd1) err_m = 1'b1;
            end else begin
                ovf_m = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(2'b00, 0, 0, 1'b1);
        cyc(2'b00, 0, 0, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; checked before any clock edge.
    task automatic do_reset();
        in_valid = 2'b11;
        resetn = 1'b0;
        #2;
        chk("rst_level", 256'(level), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        chk("rst_oerr", 256'(order_err), 256'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        in_valid = 2'b00;
        sb.delete();
        ovf_m = 1'b0;
        err_m = 1'b0;
        base_m = 1'b0;
        last_m = '0;
    endtask

    initial begin
        in_valid = 2'b11;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_valid", 256'(out_valid), 256'(0));
        chk("reset_level", 256'(level), 256'(0));
        chk("reset_ovf", 256'(overflow), 256'(0));
        chk("reset_order", 256'(out_order), 256'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        in_valid = 2'b00;

        cyc(2'b11, 10, 11, 1'b1);
        repeat (3) cyc(2'b00, 0, 0, 1'b1);

        cyc(2'b10, 0, 5, 1'b0);
        cyc(2'b00, 0, 0, 1'b0);
        cyc(2'b00, 0, 0, 1'b1);
        cyc(2'b01, 6, 0, 1'b1);
        drain();

        for (int i = 0; i < 4; i++) cyc(2'b11, 64'(20 + 2*i), 64'(21 + 2*i), 1'b0);
        cyc(2'b11, 28, 29, 1'b0);
        cyc(2'b00, 0, 0, 1'b0);
        drain();

        do_reset();
        for (int i = 0; i < 4; i++) cyc(2'b11, 64'(30 + 2*i), 64'(31 + 2*i), 1'b0);
        cyc(2'b01, 38, 0, 1'b1);
        cyc(2'b00, 0, 0, 1'b0);
        cyc(2'b11, 39, 40, 1'b1);
        drain();

        do_reset();
        cyc(2'b11, 3, 4, 1'b1);
        cyc(2'b01, 6, 0, 1'b1);
        drain();

        cyc(2'b11, 7, 8, 1'b0);
        cyc(2'b01, 9, 0, 1'b0);
        cyc(2'b00, 0, 0, 1'b1);
        do_reset();
        cyc(2'b00, 0, 0, 1'b1);
        cyc(2'b11, 50, 51, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
